// File: rtl/display_pkg.sv
// display_pkg
//   Shared definitions for the BCD display path: segment patterns
//   (active-low, bit order {g,f,e,d,c,b,a}), the converter FSM state
//   encoding, the fixed internal BCD width, and the digit decoder.
package display_pkg;

    // Ten BCD digits cover 2^32-1 = 4294967295.
    localparam int BCD_DIGITS = 10;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // BCD digit to segment pattern; codes 10..15 cannot occur in a valid
    // conversion result and show as blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3). A conversion starts
//   whenever value_in differs from the last captured value and takes
//   BIN_WIDTH CONVERT cycles plus one DONE cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   value_in    binary value to convert
//   work_bcd    BCD work register; final result is valid while done=1
//   done        one-cycle pulse in the DONE state
//   busy        high in CONVERT and DONE
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BIN_WIDTH-1:0]    value_in,
    output logic [4*BCD_DIGITS-1:0] work_bcd,
    output logic                    done,
    output logic                    busy
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    state_e                  state_q;
    logic [BIN_WIDTH-1:0]    shadow_q;
    logic [BIN_WIDTH-1:0]    shift_q;
    logic [4*BCD_DIGITS-1:0] work_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    done_q;
    logic                    busy_q;

    logic [4*BCD_DIGITS-1:0] work_adj;
    logic [4*BCD_DIGITS-1:0] work_d;

    // Correct every digit >= 5 before the shift so that it carries into
    // the next digit once doubled.
    always_comb begin
        // NOTE: assign a default first so no path through the loop leaves
        // the signal unassigned, which would infer a latch.
        work_adj = work_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        // Left shift of {work, shift}: the MSB of shift enters digit 0.
        work_d = {work_adj[4*BCD_DIGITS-2:0], shift_q[BIN_WIDTH-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            shift_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: all state updates are non-blocking so every register
            // samples values from before this edge, independent of order.
            case (state_q)
                ST_IDLE: begin
                    if (value_in != shadow_q) begin
                        shadow_q <= value_in;
                        shift_q  <= value_in;
                        work_q   <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    work_q  <= work_d;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign work_bcd = work_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: rtl/display_bcd_scan.sv
// display_bcd_scan
//   Shows an unsigned binary value in decimal on a multiplexed, active-low
//   7-segment display. The value is converted sequentially; the result is
//   latched only when a conversion finishes, so partial results never
//   reach the display.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   value_in    binary value to display
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   an          digit enables, active-low, exactly one low, registered
//   busy        conversion in progress
//   overflow    value needs more than NUM_DIGITS digits (shows dashes)
//   bcd_out     latched BCD result, digit 0 in bits [3:0]
module display_bcd_scan
    import display_pkg::*;
#(
    parameter int BIN_WIDTH  = 32,
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BIN_WIDTH-1:0]    value_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    busy,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd_out
);

    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*BCD_DIGITS-1:0] work_bcd;
    logic                    conv_done;

    bin2bcd_seq #(
        .BIN_WIDTH (BIN_WIDTH)
    ) u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .work_bcd (work_bcd),
        .done     (conv_done),
        .busy     (busy)
    );

    // Result latch and overflow flag.
    logic [4*NUM_DIGITS-1:0] disp_bcd_q;
    logic                    overflow_q;
    logic                    overflow_d;

    always_comb begin
        overflow_d = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (i >= NUM_DIGITS && work_bcd[4*i +: 4] != 4'd0) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd_q <= '0;
            overflow_q <= 1'b0;
        end else if (conv_done) begin
            disp_bcd_q <= work_bcd[4*NUM_DIGITS-1:0];
            overflow_q <= overflow_d;
        end
    end

    // Scan prescaler and digit index, free-running.
    logic [SCAN_W-1:0] presc_q;
    logic [IDX_W-1:0]  idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == SCAN_W'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Digit select, leading-zero detection and segment decode.
    logic [3:0]            cur_digit;
    logic                  upper_zero;
    logic [6:0]            seg_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;

    always_comb begin
        cur_digit  = 4'd0;
        upper_zero = 1'b1;
        an_d       = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_digit = disp_bcd_q[4*i +: 4];
                an_d[i]   = 1'b0;
            end
            // The selected digit and everything above it must be zero
            // for the digit to count as a leading zero.
            if (IDX_W'(i) >= idx_q && disp_bcd_q[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end

        if (overflow_q) begin
            seg_d = SEG_DASH;
        end else if (BLANK_LZ != 0 && idx_q != '0 && upper_zero) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(cur_digit);
        end
    end

    // Registered pin drivers; reset state selects digit 0 showing "0".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_0;
            an_q  <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign overflow = overflow_q;
    assign bcd_out  = disp_bcd_q;

endmodule

// File: tb/tb_display_bcd_scan.sv
// tb_display_bcd_scan
//   Directed bench for display_bcd_scan. Two instances share clock, reset
//   and input: dut_a blanks leading zeros, dut_b does not. Both use a
//   short scan period so digit rotation is quick to observe.
module tb_display_bcd_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] value_in;

    logic [6:0]  seg_a, seg_b;
    logic [7:0]  an_a, an_b;
    logic        busy_a, busy_b;
    logic        ovf_a, ovf_b;
    logic [31:0] bcd_a, bcd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_bcd_scan #(
        .BIN_WIDTH  (32),
        .NUM_DIGITS (8),
        .SCAN_DIV   (4),
        .BLANK_LZ   (1)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .seg      (seg_a),
        .an       (an_a),
        .busy     (busy_a),
        .overflow (ovf_a),
        .bcd_out  (bcd_a)
    );

    display_bcd_scan #(
        .BIN_WIDTH  (32),
        .NUM_DIGITS (8),
        .SCAN_DIV   (4),
        .BLANK_LZ   (0)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .seg      (seg_b),
        .an       (an_b),
        .busy     (busy_b),
        .overflow (ovf_b),
        .bcd_out  (bcd_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts falling edges with busy high, starting at the next one;
    // stops at the first idle sample or after a bounded budget.
    task automatic wait_idle(output int cycles, output logic [31:0] last_busy_bcd);
        cycles        = 0;
        last_busy_bcd = 32'hxxxx_xxxx;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b1) break;
            cycles++;
            last_busy_bcd = bcd_a;
        end
    endtask

    // Waits until digit idx is enabled on dut_a and returns both seg buses.
    task automatic get_digit(input int idx, output logic [6:0] s_a, output logic [6:0] s_b);
        logic [7:0] target;
        logic       found;
        target = ~(8'b1 << idx);
        found  = 1'b0;
        s_a    = 7'hxx;
        s_b    = 7'hxx;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (an_a === target) begin
                found = 1'b1;
                s_a   = seg_a;
                s_b   = seg_b;
                break;
            end
        end
        check($sformatf("scan_find_digit%0d", idx), found, 1'b1);
    endtask

    int          cyc;
    int          dwell;
    logic [31:0] prev_bcd;
    logic [6:0]  sa, sb;
    logic        seen;

    initial begin
        // Reset state.
        rst_n    = 1'b0;
        value_in = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_an",       an_a,   8'b1111_1110);
        check("rst_seg",      seg_a,  7'b1000000);
        check("rst_busy",     busy_a, 1'b0);
        check("rst_bcd",      bcd_a,  32'h0);
        check("rst_ovf",      ovf_a,  1'b0);
        check("rst_an_b",     an_b,   8'b1111_1110);
        check("rst_busy_b",   busy_b, 1'b0);
        check("rst_ovf_b",    ovf_b,  1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_conv_after_rst", busy_a, 1'b0);

        // 12345678: busy for 33 cycles, old result held until the end.
        value_in = 32'd12345678;
        wait_idle(cyc, prev_bcd);
        check("conv1_busy_cycles", cyc, 33);
        check("conv1_hold_prev",   prev_bcd, 32'h0);
        check("conv1_bcd",         bcd_a, 32'h12345678);
        check("conv1_ovf",         ovf_a, 1'b0);
        get_digit(0, sa, sb);
        check("conv1_dig0", sa, 7'b0000000);
        get_digit(7, sa, sb);
        check("conv1_dig7", sa, 7'b1111001);

        // 2^32-1 needs ten digits: overflow, dashes everywhere.
        value_in = 32'd4294967295;
        wait_idle(cyc, prev_bcd);
        check("max_busy_cycles", cyc, 33);
        check("max_ovf",         ovf_a, 1'b1);
        check("max_bcd_low8",    bcd_a, 32'h94967295);
        get_digit(0, sa, sb);
        check("max_dig0_dash", sa, 7'b0111111);
        get_digit(3, sa, sb);
        check("max_dig3_dash", sa, 7'b0111111);
        get_digit(7, sa, sb);
        check("max_dig7_dash", sa, 7'b0111111);

        // 7: overflow clears, upper digits blanked.
        value_in = 32'd7;
        wait_idle(cyc, prev_bcd);
        check("seven_ovf", ovf_a, 1'b0);
        check("seven_bcd", bcd_a, 32'h7);
        get_digit(0, sa, sb);
        check("seven_dig0", sa, 7'b1111000);
        get_digit(1, sa, sb);
        check("seven_dig1_blank", sa, 7'b1111111);
        get_digit(7, sa, sb);
        check("seven_dig7_blank", sa, 7'b1111111);

        // 42: scan rotation and leading-zero handling on both instances.
        value_in = 32'd42;
        wait_idle(cyc, prev_bcd);
        check("fortytwo_bcd",   bcd_a, 32'h42);
        check("fortytwo_bcd_b", bcd_b, 32'h42);
        get_digit(0, sa, sb);
        check("ft_dig0_a", sa, 7'b0100100);
        check("ft_dig0_b", sb, 7'b0100100);
        get_digit(1, sa, sb);
        check("ft_dig1_a", sa, 7'b0011001);
        get_digit(2, sa, sb);
        check("ft_dig2_blank_a", sa, 7'b1111111);
        check("ft_dig2_zero_b",  sb, 7'b1000000);
        get_digit(7, sa, sb);
        check("ft_dig7_blank_a", sa, 7'b1111111);
        check("ft_dig7_zero_b",  sb, 7'b1000000);

        // Dwell of 4 cycles per digit and wrap from digit 7 to digit 0.
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an_a !== 8'h7F) begin
                seen = 1'b1;
                break;
            end
        end
        check("scan_leave7", seen, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an_a === 8'h7F) begin
                seen = 1'b1;
                break;
            end
        end
        check("scan_reach7", seen, 1'b1);
        dwell = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an_a !== 8'h7F) break;
            dwell++;
        end
        check("scan_dwell", dwell, 4);
        check("scan_wrap",  an_a, 8'hFE);
        repeat (4) @(negedge clk);
        check("scan_step",  an_a, 8'hFD);

        // 10 then 55 five cycles later: both complete back to back.
        value_in = 32'd10;
        repeat (5) @(negedge clk);
        value_in = 32'd55;
        wait_idle(cyc, prev_bcd);
        check("ten_busy_cycles", cyc + 5, 33);
        check("ten_bcd",         bcd_a, 32'h10);
        @(negedge clk);
        check("fiftyfive_start", busy_a, 1'b1);
        wait_idle(cyc, prev_bcd);
        check("fiftyfive_busy_cycles", cyc + 1, 33);
        check("fiftyfive_bcd",  bcd_a, 32'h55);

        // 999 interrupted by reset 10 cycles into the conversion.
        value_in = 32'd999;
        repeat (10) @(negedge clk);
        check("mid_busy", busy_a, 1'b1);
        check("mid_hold", bcd_a,  32'h55);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_a, 1'b0);
        check("abort_bcd",  bcd_a,  32'h0);
        check("abort_an",   an_a,   8'b1111_1110);
        check("abort_seg",  seg_a,  7'b1000000);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(cyc, prev_bcd);
        check("rerun_busy_cycles", cyc, 33);
        check("rerun_bcd",         bcd_a, 32'h999);
        check("rerun_ovf",         ovf_a, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
